// File: rtl/cordic_pkg.sv
// Shared widths, latency and FSM encoding for the CORDIC NCO front end.
package cordic_pkg;
  localparam int PHASE_W    = 32;
  localparam int DATA_W     = 16;
  localparam int CORDIC_LAT = 16;
  localparam int AMP_MAX    = 19898;
  localparam logic [PHASE_W-1:0] ANG_90 = 32'h4000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/cordic_valid_delay.sv
// Sample-tag delay line matching the rotator latency; empty covers the input tap too.
module cordic_valid_delay
  import cordic_pkg::*;
#(
  parameter int DEPTH = CORDIC_LAT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld_i,
  output logic tap_o,
  output logic empty_o
);

  logic [DEPTH-1:0] vld_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], vld_i};
    end
  end

  assign tap_o   = vld_q[DEPTH-1];
  assign empty_o = ~(|vld_q) & ~vld_i;

endmodule

// File: rtl/cordic_nco_driver.sv
// Phase-accumulator NCO driving a pipelined CORDIC rotator; out_valid tracks rotator latency.
module cordic_nco_driver
  import cordic_pkg::*;
(
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PHASE_W-1:0]        cfg_freq,
  input  logic [PHASE_W-1:0]        cfg_phase,
  input  logic signed [DATA_W-1:0]  cfg_amp,
  input  logic [15:0]               cfg_count,
  input  logic                      run,
  output logic signed [DATA_W-1:0]  xin,
  output logic signed [DATA_W-1:0]  yin,
  output logic [PHASE_W-1:0]        zangle,
  output logic                      out_valid,
  output logic                      busy
);

  localparam logic signed [DATA_W-1:0] AMP_LIM = DATA_W'(AMP_MAX);

  // Keeps the rotator's first stage from overflowing after the 1.647 CORDIC gain.
  function automatic logic signed [DATA_W-1:0] clamp_amp(input logic signed [DATA_W-1:0] a);
    if (a < 0) begin
      return '0;
    end else if (a > AMP_LIM) begin
      return AMP_LIM;
    end else begin
      return a;
    end
  endfunction

  state_e                     state_q, state_d;
  logic [PHASE_W-1:0]         acc_q, acc_d;
  logic [PHASE_W-1:0]         freq_q, freq_d;
  logic signed [DATA_W-1:0]   amp_q, amp_d;
  logic [15:0]                remain_q, remain_d;
  logic                       cont_q, cont_d;
  logic [PHASE_W-1:0]         zangle_q, zangle_d;
  logic signed [DATA_W-1:0]   xin_q, xin_d;
  logic                       issue_q, issue_d;
  logic                       ready_q, busy_q;
  logic                       pipe_empty;
  logic                       vld_tap;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    freq_d   = freq_q;
    amp_d    = amp_q;
    remain_d = remain_q;
    cont_d   = cont_q;
    zangle_d = zangle_q;
    xin_d    = xin_q;
    issue_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          freq_d   = cfg_freq;
          acc_d    = cfg_phase;
          remain_d = cfg_count;
          cont_d   = (cfg_count == 16'd0);
          amp_d    = clamp_amp(cfg_amp);
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = DRAIN;
        end else begin
          issue_d  = 1'b1;
          zangle_d = acc_q;
          xin_d    = amp_q;
          acc_d    = acc_q + freq_q;
          if (!cont_q) begin
            remain_d = remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        // Hold angle/amplitude so the rotator input stays quiet while tags drain.
        if (pipe_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      freq_q   <= '0;
      amp_q    <= '0;
      remain_q <= '0;
      cont_q   <= 1'b0;
      zangle_q <= '0;
      xin_q    <= '0;
      issue_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      amp_q    <= amp_d;
      remain_q <= remain_d;
      cont_q   <= cont_d;
      zangle_q <= zangle_d;
      xin_q    <= xin_d;
      issue_q  <= issue_d;
      ready_q  <= (state_d == IDLE);
      busy_q   <= (state_d != IDLE);
    end
  end

  cordic_valid_delay #(.DEPTH(CORDIC_LAT)) u_vld (
    .clock   (clock),
    .resetn  (resetn),
    .vld_i   (issue_q),
    .tap_o   (vld_tap),
    .empty_o (pipe_empty)
  );

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign zangle    = zangle_q;
  assign xin       = xin_q;
  assign yin       = '0;
  assign out_valid = vld_tap;

endmodule

// File: tb/tb_cordic_nco_driver.sv
// Table-driven and randomized bench for cordic_nco_driver against a per-transaction sample model.
module tb_cordic_nco_driver;

  localparam int LAT  = 16;
  localparam int AMPM = 19898;
  localparam int MAXJ = 48;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [31:0]        cfg_freq = '0;
  logic [31:0]        cfg_phase = '0;
  logic signed [15:0] cfg_amp = '0;
  logic [15:0]        cfg_count = '0;
  logic               run = 1'b0;
  logic signed [15:0] xin, yin;
  logic [31:0]        zangle;
  logic               out_valid, busy;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_nco_driver dut (
    .clock(clock), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp), .cfg_count(cfg_count),
    .run(run), .xin(xin), .yin(yin), .zangle(zangle), .out_valid(out_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]        phase;
    logic [31:0]        freq;
    logic signed [15:0] amp;
    logic [15:0]        count;
    int                 nrun;
    bit                 hold_cfg;
    bit                 has_exp;
    logic [31:0]        exp_z1;
    logic signed [15:0] exp_xin;
    int                 exp_n;
  } txn_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic signed [15:0] m_clamp(input int a);
    if (a < 0) return 16'sd0;
    if (a > AMPM) return 16'(AMPM);
    return 16'(a);
  endfunction

  function automatic logic [31:0] m_angle(input logic [31:0] ph, input logic [31:0] fr, input int k);
    logic [63:0] t;
    t = {32'd0, ph} + 64'(k) * {32'd0, fr};
    return t[31:0];
  endfunction

  function automatic txn_t mk(input logic [31:0] ph, input logic [31:0] fr, input int amp,
                              input int cnt, input int nrun, input bit hold,
                              input logic [31:0] z1, input int xe, input int ne);
    txn_t t;
    t.phase = ph; t.freq = fr; t.amp = 16'(amp); t.count = 16'(cnt); t.nrun = nrun;
    t.hold_cfg = hold; t.has_exp = 1'b1; t.exp_z1 = z1; t.exp_xin = 16'(xe); t.exp_n = ne;
    return t;
  endfunction

  task automatic do_txn(input txn_t t);
    logic [31:0]        zh [MAXJ];
    logic signed [15:0] xh [MAXJ];
    bit                 vh [MAXJ];
    bit                 bh [MAXJ];
    bit                 rh [MAXJ];
    int n, jl, nv, first, last, wc, rdy_seen;
    n  = (t.count == 0) ? t.nrun : ((t.nrun < int'(t.count)) ? t.nrun : int'(t.count));
    jl = n + 1 + LAT;
    wc = 0;
    while (!cfg_ready && wc < 200) begin
      @(negedge clock);
      wc++;
    end
    check("cfg_ready_wait", cfg_ready, 1);
    cfg_phase = t.phase; cfg_freq = t.freq; cfg_amp = t.amp; cfg_count = t.count;
    cfg_valid = 1'b1; run = 1'b1;
    @(negedge clock);
    if (t.hold_cfg) begin
      cfg_phase = ~t.phase; cfg_freq = t.freq + 32'h1234; cfg_amp = 16'sd77; cfg_count = 16'd2;
    end else begin
      cfg_valid = 1'b0;
    end
    for (int j = 0; j < MAXJ; j++) begin
      zh[j] = zangle; xh[j] = xin; vh[j] = out_valid; bh[j] = busy; rh[j] = cfg_ready;
      run = (j <= t.nrun);
      if (j >= jl) cfg_valid = 1'b0;
      @(negedge clock);
    end
    run = 1'b0;
    cfg_valid = 1'b0;
    nv = 0; first = -1; last = -1;
    for (int j = 0; j < MAXJ; j++) begin
      if (vh[j]) begin
        if (first < 0) first = j;
        last = j;
        if (j >= LAT) begin
          check("sample_zangle", zh[j-LAT], m_angle(t.phase, t.freq, nv));
          check("sample_xin", xh[j-LAT], m_clamp(int'(t.amp)));
        end
        nv++;
      end
    end
    check("n_valid", nv, n);
    check("first_valid", first, 2 + LAT);
    check("last_valid", last, jl);
    check("armed_ready", rh[0], 0);
    check("busy_before_empty", bh[jl+1], 1);
    check("busy_after_empty", bh[jl+2], 0);
    check("ready_after_empty", rh[jl+2], 1);
    if (t.hold_cfg) begin
      rdy_seen = 0;
      for (int j = 0; j <= jl + 1; j++) if (rh[j]) rdy_seen++;
      check("ready_held_low", rdy_seen, 0);
    end
    if (t.has_exp) begin
      check("tbl_second_zangle", zh[3], t.exp_z1);
      check("tbl_xin", xh[2], t.exp_xin);
      check("tbl_n_valid", nv, t.exp_n);
    end
  endtask

  txn_t tbl [9];
  txn_t rt;
  int   stale;

  initial begin
    tbl[0] = mk(32'h0000_0000, 32'h1000_0000, 1000,   8, 20, 1'b0, 32'h1000_0000, 1000,  8);
    tbl[1] = mk(32'h0000_0000, 32'h0000_0100, 32767,  3,  3, 1'b0, 32'h0000_0100, 19898, 3);
    tbl[2] = mk(32'h0000_0055, 32'h0000_0100, -5,     3,  3, 1'b0, 32'h0000_0155, 0,     3);
    tbl[3] = mk(32'hFFFF_FFF0, 32'h0000_0020, 200,    4,  4, 1'b0, 32'h0000_0010, 200,   4);
    tbl[4] = mk(32'h0000_1000, 32'h0000_0010, 300,    0,  5, 1'b0, 32'h0000_1010, 300,   5);
    tbl[5] = mk(32'h0000_2000, 32'h0000_0000, 400,    6,  6, 1'b1, 32'h0000_2000, 400,   6);
    tbl[6] = mk(32'h0000_0000, 32'h8000_0000, 19898,  4, 10, 1'b0, 32'h8000_0000, 19898, 4);
    tbl[7] = mk(32'h0000_0077, 32'h0000_0005, 50,     1,  5, 1'b0, 32'h0000_0077, 50,    1);
    tbl[8] = mk(32'h0000_0010, 32'h0000_0010, 20000, 10,  3, 1'b0, 32'h0000_0020, 19898, 3);

    repeat (2) @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_zangle", zangle, 0);
    check("rst_xin", xin, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 9; i++) do_txn(tbl[i]);

    for (int i = 0; i < 25; i++) begin
      rt.phase = $urandom;
      rt.freq = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
      rt.amp = 16'($urandom);
      rt.count = 16'($urandom_range(0, 10));
      rt.nrun = $urandom_range(1, 14);
      rt.hold_cfg = ($urandom_range(0, 3) == 0);
      rt.has_exp = 1'b0;
      rt.exp_z1 = '0; rt.exp_xin = '0; rt.exp_n = 0;
      do_txn(rt);
    end

    // Reset mid-run with the valid pipe partly loaded.
    cfg_phase = 32'h1234; cfg_freq = 32'h100; cfg_amp = 16'sd500; cfg_count = 16'd0;
    cfg_valid = 1'b1; run = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    repeat (10) @(negedge clock);
    check("pre_rst_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    @(posedge clock); #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_zangle", zangle, 0);
    check("mid_rst_cfg_ready", cfg_ready, 1);
    run = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    stale = 0;
    for (int j = 0; j < LAT + 6; j++) begin
      @(negedge clock);
      if (out_valid || busy) stale++;
    end
    check("no_stale_after_rst", stale, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
